instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//  Assembles 32-bit ARM-format instruction words from field-level requests
//  (type, subtype, cond, registers, immediates) and queues them for the
//  instruction-memory writer / decoder front end. It is the producer side of the
//  decoder: bits [27:26], 25, 7 and 4 carry the class/subtype codes the decoder
//  classifies. A registered encode stage feeds an output FIFO, with valid/ready
//  handshakes on both sides.
// PARAMETERS
//  FIFO_DEPTH  4   output queue entries (power of 2, >=2)
//  CNT_W       16  width of issued-instruction counter
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        synchronous reset, active-high
//  in_valid     in   1        request valid
//  in_ready     out  1        encoder can accept request
//  in_type      in   2        01 data-proc, 10 memory, 11 branch, 00 illegal
//  in_sub       in   3        data subtype: 001 imm, 010 reg-imm-shift, 011 reg-reg-shift
//  in_cond      in   4        condition field -> [31:28]
//  in_opcode    in   4        data-proc opcode -> [24:21]
//  in_s         in   1        set-flags -> [20] (data-proc)
//  in_rn        in   4        Rn -> [19:16]
//  in_rd        in   4        Rd -> [15:12]
//  in_op2       in   12       operand2 / memory offset -> [11:0]
//  in_mem_flags in   6        {I_n,P,U,B,W,L} -> [25:20] (memory)
//  in_link      in   1        branch-with-link -> [24]
//  in_imm24     in   24       branch offset -> [23:0]
//  out_valid    out  1        out_instr valid
//  out_ready    in   1        consumer takes word
//  out_instr    out  32       encoded instruction (FIFO head)
//  err          out  1        1-cycle pulse: illegal request dropped
//  instr_count  out  CNT_W    words pushed into FIFO since reset
//  fifo_level   out  clog2(FIFO_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset: in_ready=0 while rst=1; out_valid=0, out_instr=0, err=0,
//   instr_count=0, fifo_level=0, stage empty, FIFO pointers cleared. Reset
//   mid-operation drops stage and all queued words.
//  Accept: transfer when in_valid && in_ready at edge N; fields captured to stage.
//  in_ready = !rst && (fifo_level + stage_valid) < FIFO_DEPTH, from registers only;
//   a same-cycle pop is NOT credited (conservative, no comb path out_ready->in_ready).
//  Encoding (stage, combinational from captured fields):
//   data 001: {cond,2'b00,1'b1,opcode,s,rn,rd,op2}
//   data 010: {cond,2'b00,1'b0,opcode,s,rn,rd,op2[11:5],1'b0,op2[3:0]}
//   data 011: {cond,2'b00,1'b0,opcode,s,rn,rd,op2[11:8],1'b0,op2[6:5],1'b1,op2[3:0]}
//   memory:   {cond,2'b01,mem_flags,rn,rd,op2}
//   branch:   {cond,3'b101,link,imm24}
//  Illegal: in_type=00, or data with in_sub not in {001,010,011}: word not pushed,
//   err=1 during edge N+1..N+2 cycle, instr_count unchanged.
//  Stage valid at N+1 pushes to FIFO at edge N+1 (space guaranteed by in_ready);
//   with FIFO empty, out_valid=1 and out_instr valid after edge N+1 (latency 2).
//  Output: pop on out_valid && out_ready; out_instr/out_valid stable while
//   out_valid && !out_ready. Strict FIFO order. Simultaneous push+pop: level held.
//  Pointers wrap modulo FIFO_DEPTH; instr_count wraps modulo 2^CNT_W.
//  Back-to-back accepts sustain 1 word/cycle while out_ready=1.
// TESTING
//  T1 data 001 cond=E op=0100 s=0 rn=1 rd=2 op2=005 -> out_instr=32'hE2812005, 2-cycle latency
//  T2 data 010 cond=E op=1101 rn=0 rd=5 op2=013 -> 32'hE1A05003 (bit4 forced 0)
//  T3 mem cond=E flags=011001 rn=3 rd=4 op2=010 -> 32'hE5934010; branch link=1
//     imm24=000010 -> 32'hEB000010; instr_count=2 after both
//  T4 out_ready=0, offer 6 legal requests: exactly 4 accepted, in_ready=0, level=4;
//     raise out_ready -> 4 words out in order, then remaining 2 accepted
//  T5 in_type=00 then data in_sub=111 -> two err pulses, no out_valid, count unchanged
//  T6 assert rst with 3 words queued and stage full -> next cycle out_valid=0,
//     level=0, count=0; first request after reset encodes correctly

Source files
------------

// File: rtl/instr_encoder.sv
// ============================================================================
//  Module      : instr_encoder
//  Description : Builds 32-bit ARM-format instruction words from field-level
//                requests through a one-entry encode stage and an output FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [1:0]                      in_type,
    input  logic [2:0]                      in_sub,
    input  logic [3:0]                      in_cond,
    input  logic [3:0]                      in_opcode,
    input  logic                            in_s,
    input  logic [3:0]                      in_rn,
    input  logic [3:0]                      in_rd,
    input  logic [11:0]                     in_op2,
    input  logic [5:0]                      in_mem_flags,
    input  logic                            in_link,
    input  logic [23:0]                     in_imm24,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [31:0]                     out_instr,
    output logic                            err,
    output logic [CNT_W-1:0]                instr_count,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam int              LVL_W   = PTR_W + 1;
    localparam logic [LVL_W:0]  C_DEPTH = (LVL_W + 1)'(FIFO_DEPTH);

    logic              r_stg_valid;
    logic [1:0]        r_type;
    logic [2:0]        r_sub;
    logic [3:0]        r_cond;
    logic [3:0]        r_opcode;
    logic              r_s;
    logic [3:0]        r_rn;
    logic [3:0]        r_rd;
    logic [11:0]       r_op2;
    logic [5:0]        r_mflags;
    logic              r_link;
    logic [23:0]       r_imm24;

    logic [31:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [LVL_W-1:0]  r_level;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;

    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_acc;
    logic              w_push;
    logic              w_pop;
    logic [LVL_W:0]    w_occ;

    // Occupancy counts the staged word so a push always finds room; pops are
    // deliberately not credited to keep out_ready off the in_ready path.
    assign w_occ     = {1'b0, r_level} + {{LVL_W{1'b0}}, r_stg_valid};
    assign in_ready  = !rst && (w_occ < C_DEPTH);
    assign w_acc     = in_valid && in_ready;
    assign w_push    = r_stg_valid && w_legal;
    assign out_valid = (r_level != '0);
    assign w_pop     = out_valid && out_ready;
    assign out_instr = out_valid ? r_mem[r_rptr] : 32'h0;

    assign err         = r_err;
    assign instr_count = r_count;
    assign fifo_level  = r_level;

    always_comb begin
        w_word  = 32'h0;
        w_legal = 1'b0;
        case (r_type)
            2'b01: begin
                case (r_sub)
                    3'b001: begin
                        w_word  = {r_cond, 2'b00, 1'b1, r_opcode, r_s, r_rn, r_rd, r_op2};
                        w_legal = 1'b1;
                    end
                    3'b010: begin
                        w_word  = {r_cond, 2'b00, 1'b0, r_opcode, r_s, r_rn, r_rd,
                                   r_op2[11:5], 1'b0, r_op2[3:0]};
                        w_legal = 1'b1;
                    end
                    3'b011: begin
                        w_word  = {r_cond, 2'b00, 1'b0, r_opcode, r_s, r_rn, r_rd,
                                   r_op2[11:8], 1'b0, r_op2[6:5], 1'b1, r_op2[3:0]};
                        w_legal = 1'b1;
                    end
                    default: begin
                        w_word  = 32'h0;
                        w_legal = 1'b0;
                    end
                endcase
            end
            2'b10: begin
                w_word  = {r_cond, 2'b01, r_mflags, r_rn, r_rd, r_op2};
                w_legal = 1'b1;
            end
            2'b11: begin
                w_word  = {r_cond, 3'b101, r_link, r_imm24};
                w_legal = 1'b1;
            end
            default: begin
                w_word  = 32'h0;
                w_legal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_type   <= in_type;
            r_sub    <= in_sub;
            r_cond   <= in_cond;
            r_opcode <= in_opcode;
            r_s      <= in_s;
            r_rn     <= in_rn;
            r_rd     <= in_rd;
            r_op2    <= in_op2;
            r_mflags <= in_mem_flags;
            r_link   <= in_link;
            r_imm24  <= in_imm24;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_valid <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_stg_valid <= w_acc;
            r_err       <= r_stg_valid && !w_legal;
            if (w_push) begin
                r_wptr  <= r_wptr + 1'b1;
                r_count <= r_count + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

`default_nettype wire
